// File: rtl/seg_display_pkg.sv
// Shared glyph constants, chime state encoding and the BCD-to-glyph helper
// for the multiplexed 7-segment display and its chime sequencer.
package seg_display_pkg;

  // Glyphs are active-low {g,f,e,d,c,b,a}; the decimal point is added separately
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] DP_MASK   = 8'h80;

  typedef enum logic [1:0] {CH_IDLE, CH_ON, CH_OFF} chime_state_t;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/chime_seq.sv
// Hourly chime sequencer: rising-edge detect on chime_req, then BEEP_COUNT
// beeps of BEEP_ON cycles separated by BEEP_OFF cycles of silence.
module chime_seq
  import seg_display_pkg::*;
#(
  parameter int BEEP_ON    = 5000000,
  parameter int BEEP_OFF   = 5000000,
  parameter int BEEP_COUNT = 3
) (
  input  logic clk,
  input  logic key0,
  input  logic chime_req,
  output logic buzzer,
  output logic busy
);

  localparam int PHASE_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int CW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int RW = $clog2(BEEP_COUNT + 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(BEEP_ON - 1);
  localparam logic [CW-1:0] OFF_LAST   = CW'(BEEP_OFF - 1);
  localparam logic [RW-1:0] COUNT_INIT = RW'(BEEP_COUNT);
  localparam logic [RW-1:0] COUNT_ONE  = RW'(1);

  chime_state_t    state;
  logic            req_q;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   remaining;

  // req_q resets high so a request already held across reset release is not an edge
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      state     <= CH_IDLE;
      req_q     <= 1'b1;
      cnt       <= '0;
      remaining <= '0;
      buzzer    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req_q  <= chime_req;
      buzzer <= (state == CH_ON);
      busy   <= (state != CH_IDLE);
      case (state)
        CH_IDLE: begin
          if (chime_req && !req_q) begin
            state     <= CH_ON;
            cnt       <= '0;
            remaining <= COUNT_INIT;
          end
        end
        CH_ON: begin
          if (cnt == ON_LAST) begin
            cnt       <= '0;
            remaining <= remaining - 1'b1;
            state     <= (remaining == COUNT_ONE) ? CH_IDLE : CH_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CH_OFF: begin
          if (cnt == OFF_LAST) begin
            cnt   <= '0;
            state <= CH_ON;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed common-anode display with per-field blinking and chime.
// Optional LEADING_ZERO_BLANK_EN blanks digit 5 when its shadow value is zero.
module seg_scan_display
  import seg_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 8333,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_HALF   = 25000000,
  parameter int BEEP_ON      = 5000000,
  parameter int BEEP_OFF     = 5000000,
  parameter int BEEP_COUNT   = 3
) (
  input  logic       clk,
  input  logic       key0,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic [3:0] hex4,
  input  logic [3:0] hex5,
  input  logic       ld,
  input  logic [2:0] blink_mask,
  input  logic       chime_req,
  output logic [7:0] seg,
  output logic [5:0] dig_sel,
  output logic       buzzer,
  output logic       busy
);

  localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [23:0]   shadow;
  logic [2:0]    idx;
  logic [DW-1:0] dwell;
  logic [2:0]    mask_q;
  logic [BW-1:0] blink_cnt;
  logic          hidden;
  logic [3:0]    digit;
  logic [6:0]    glyph;
  logic          blank_digit;
  logic [7:0]    seg_next;
  logic [5:0]    dig_next;

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      shadow <= '0;
    end else if (ld) begin
      shadow <= {hex5, hex4, hex3, hex2, hex1, hex0};
    end
  end

  // The mask is sampled at each digit boundary so a change never splits a dwell
  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      dwell  <= '0;
      idx    <= '0;
      mask_q <= '0;
    end else if (dwell == DWELL_LAST) begin
      dwell  <= '0;
      mask_q <= blink_mask;
      idx    <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      blink_cnt <= '0;
      hidden    <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      hidden    <= ~hidden;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    digit       = shadow[{idx, 2'b00} +: 4];
    glyph       = seg_glyph(digit);
    blank_digit = hidden && mask_q[idx[2:1]];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3'd5 && digit == 4'd0) blank_digit = 1'b1;
`endif
    dig_next = 6'h3F;
    seg_next = {1'b1, SEG_BLANK};
    if (dwell >= BLANK_END) begin
      dig_next = ~(6'd1 << idx);
      if (!blank_digit) begin
        seg_next = {1'b1, glyph};
        if (idx == 3'd2 || idx == 3'd4) seg_next = seg_next & ~DP_MASK;
      end
    end
  end

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      seg     <= 8'hFF;
      dig_sel <= 6'h3F;
    end else begin
      seg     <= seg_next;
      dig_sel <= dig_next;
    end
  end

  chime_seq #(
    .BEEP_ON   (BEEP_ON),
    .BEEP_OFF  (BEEP_OFF),
    .BEEP_COUNT(BEEP_COUNT)
  ) u_chime (
    .clk      (clk),
    .key0     (key0),
    .chime_req(chime_req),
    .buzzer   (buzzer),
    .busy     (busy)
  );

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: randomized digit/mask loads against
// an arithmetic scan model, plus directed chime and reset scenarios.
module tb_seg_scan_display;

  localparam int D    = 4;
  localparam int BL   = 1;
  localparam int BH   = 32;
  localparam int BON  = 3;
  localparam int BOFF = 2;
  localparam int BCNT = 3;

  logic       clk = 1'b0;
  logic       key0 = 1'b0;
  logic [3:0] hex0 = '0, hex1 = '0, hex2 = '0, hex3 = '0, hex4 = '0, hex5 = '0;
  logic       ld = 1'b0;
  logic [2:0] blink_mask = '0;
  logic       chime_req = 1'b0;
  logic [7:0] seg;
  logic [5:0] dig_sel;
  logic       buzzer;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int edges = 0;
  logic [3:0] model_digits [6];

  seg_scan_display #(
    .DIGIT_CYCLES(D), .BLANK_CYCLES(BL), .BLINK_HALF(BH),
    .BEEP_ON(BON), .BEEP_OFF(BOFF), .BEEP_COUNT(BCNT)
  ) dut (
    .clk(clk), .key0(key0),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .ld(ld), .blink_mask(blink_mask), .chime_req(chime_req),
    .seg(seg), .dig_sel(dig_sel), .buzzer(buzzer), .busy(busy)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the pins after edge e reflect scan step e-1
  always @(posedge clk or negedge key0) begin
    if (!key0) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  function automatic logic [13:0] model_pins(input int e);
    int n, dw, ix, d;
    logic hid;
    logic [7:0] s;
    logic [5:0] ds;
    if (e == 0) return {8'hFF, 6'h3F};
    n   = e - 1;
    dw  = n % D;
    ix  = (n / D) % 6;
    hid = ((n / BH) % 2) == 1;
    if (dw < BL) return {8'hFF, 6'h3F};
    ds = 6'h3F & ~(6'd1 << ix);
    d  = int'(model_digits[ix]);
    if (hid && blink_mask[ix / 2]) s = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    else if (ix == 5 && d == 0) s = 8'hFF;
`endif
    else begin
      s = ref_glyph(d);
      if (ix == 2 || ix == 4) s[7] = 1'b0;
    end
    return {s, ds};
  endfunction

  // Drive digits (hex0 in the low nibble) for one cycle, optionally strobing ld
  task automatic applyStimulus(input logic [23:0] digits, input logic pulse);
    {hex5, hex4, hex3, hex2, hex1, hex0} = digits;
    ld = pulse;
    if (pulse) for (int i = 0; i < 6; i++) model_digits[i] = digits[i*4 +: 4];
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic check_display(input int n);
    logic [13:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = model_pins(edges);
      checkOutput("seg", 16'(seg), 16'(exp[13:6]));
      checkOutput("dig_sel", 16'(dig_sel), 16'(exp[5:0]));
    end
  endtask

  // Position p counts negedges after chime_req rises: beeps at 1-3, 6-8, 11-13
  task automatic run_chime(input bit do_reset);
    bit eb;
    chime_req = 1'b1;
    for (int p = 0; p < 25; p++) begin
      @(negedge clk);
      eb = (p >= 1 && p <= 3) || (p >= 6 && p <= 8) || (p >= 11 && p <= 13);
      checkOutput("buzzer", 16'(buzzer), 16'(eb));
      checkOutput("busy", 16'(busy), 16'(p >= 1 && p <= 13));
      if (do_reset && p == 7) begin
        #1 key0 = 1'b0;
        #1;
        checkOutput("rst_buzzer", 16'(buzzer), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_seg", 16'(seg), 16'hFF);
        checkOutput("rst_dig_sel", 16'(dig_sel), 16'h3F);
        for (int i = 0; i < 6; i++) model_digits[i] = '0;
        return;
      end
      if (p == 4) chime_req = 1'b0;
      if (p == 6) chime_req = 1'b1;
    end
    chime_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) model_digits[i] = '0;
    #12;
    checkOutput("reset_seg", 16'(seg), 16'hFF);
    checkOutput("reset_dig_sel", 16'(dig_sel), 16'h3F);
    checkOutput("reset_buzzer", 16'(buzzer), 16'h0);
    @(negedge clk);
    key0 = 1'b1;
    check_display(8);

    $display("[TB] scan of 1..6");
    applyStimulus(24'h654321, 1'b1);
    check_display(2 * 6 * D);

    $display("[TB] shadow hold and reload");
    applyStimulus(24'h999999, 1'b0);
    check_display(6 * D);
    applyStimulus(24'h999999, 1'b1);
    check_display(6 * D);

    $display("[TB] invalid code and field blink");
    blink_mask = 3'b010;
    applyStimulus(24'h65C321, 1'b1);
    repeat (2 * D) @(negedge clk);
    check_display(4 * BH);
    blink_mask = 3'b000;

    $display("[TB] zero in digit 5");
    applyStimulus(24'h0A9870, 1'b1);
    repeat (2 * D) @(negedge clk);
    check_display(2 * 6 * D);

    for (int r = 0; r < 4; r++) begin
      blink_mask = 3'($urandom_range(7));
      applyStimulus(24'($urandom), 1'b1);
      repeat (2 * D) @(negedge clk);
      check_display(80);
    end

    $display("[TB] chime sequence");
    blink_mask = 3'b000;
    run_chime(1'b0);
    repeat (4) @(negedge clk);
    checkOutput("idle_buzzer", 16'(buzzer), 16'h0);

    $display("[TB] reset during second beep");
    run_chime(1'b1);
    chime_req = 1'b1;
    repeat (2) @(negedge clk);
    key0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("post_rst_buzzer", 16'(buzzer), 16'h0);
      checkOutput("post_rst_busy", 16'(busy), 16'h0);
    end
    check_display(6 * D);
    chime_req = 1'b0;

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Consumer end of the clock/calendar digit interface. Takes the six 4-bit BCD digits hex0..hex5 and the hourly chime pulse. Drives a multiplexed 6-digit common-anode 7-segment display with field blinking for set mode, plus a beep sequencer for the buzzer. Sits between the timekeeping core and the board pins.

Parameters:
DIGIT_CYCLES, 8333, clk cycles each digit is selected (dwell); minimum 2
BLANK_CYCLES, 16, cycles at the start of each dwell with all digits off (ghost suppression); must be < DIGIT_CYCLES
BLINK_HALF, 25000000, clk cycles per blink half-period
BEEP_ON, 5000000, cycles the buzzer is on per beep
BEEP_OFF, 5000000, cycles of silence between beeps
BEEP_COUNT, 3, beeps per chime; minimum 1

Ports:
clk  in  1  system clock
key0  in  1  reset, asynchronous, active-low
hex0..hex5  in  4 each  BCD digits; hex0 is least significant (units of right field)
ld  in  1  load strobe; samples all six digits into the shadow register
blink_mask  in  3  bit k=1 blinks field k (digits 2k, 2k+1)
chime_req  in  1  chime request level; a rising edge starts a sequence
seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
dig_sel  out  6  active-low one-hot digit enable; bit i = digit i
buzzer  out  1  active-high buzzer drive
busy  out  1  1 while a chime sequence runs

Behaviour:
- Reset (key0=0, async): seg=8'hFF, dig_sel=6'h3F, buzzer=0, busy=0, shadow=0, digit index=0, all counters 0, blink phase=visible, chime FSM=IDLE, chime_req edge register=1.
- Shadow: when ld=1, all six digits are captured in the same cycle. The display shows only the shadow; hex inputs are ignored when ld=0.
- Scan: idx counts 0..5, then wraps to 0. The dwell counter runs 0..DIGIT_CYCLES-1 and idx advances at the terminal count. While dwell < BLANK_CYCLES, dig_sel=6'h3F and seg=8'hFF.
- Otherwise dig_sel bit idx=0 and the other bits are 1. seg is the encoding of shadow[idx].
- seg and dig_sel are registered: there is 1 cycle of latency from the idx/dwell state to the pins.
- Encoding: 0-9 use standard glyphs. Codes 10-15 show a dash (only g lit, seg=8'hBF before dp).
- dp (bit7) is lit (0) on digits 2 and 4 as field separators. A blanked digit has dp off.
- Blink: the phase toggles every BLINK_HALF cycles. In the hidden phase, the digits of any field with blink_mask[k]=1 drive seg=8'hFF. dig_sel still scans normally.
- blink_mask change takes effect on the next displayed digit. The phase counter is not reset by a mask change.
- Chime FSM: IDLE -> ON on a chime_req rising edge (req=1 and the registered previous value=0); remaining is loaded with BEEP_COUNT.
- ON: buzzer=1 for BEEP_ON cycles, then remaining decrements. If remaining is now 0, go to IDLE; otherwise go to OFF.
- OFF: buzzer=0 for BEEP_OFF cycles, then go to ON.
- busy=1 in ON and OFF. Rising edges during busy are ignored, not queued.
- Buzzer asserts on the cycle after the edge is registered. It is a registered output with 1-cycle latency from FSM entry.
- chime_req held high across reset release does not trigger, because the edge register resets to 1.
- Reset mid-beep aborts immediately: buzzer=0, FSM IDLE.
- Counter widths are sized with $clog2 of their respective parameter. No wrap-around beyond the terminal counts.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when shadow hex5==0, digit 5 shows blank (seg=8'hFF).
- Not defined: digit 5 shows "0" normally.
- Digits 0-4 are unaffected either way.

Decomposition:
- Package seg_display_pkg: 7-segment glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-low, dp excluded), DP_MASK, and the chime state enum {CH_IDLE, CH_ON, CH_OFF}.
- Sub-module chime_seq: edge detector, chime FSM and beep counters. Outputs buzzer and busy.
- seg_scan_display contains the shadow, scan, blink and encode logic, and instantiates chime_seq.

Test Plan:
Bench parameters: DIGIT_CYCLES=4, BLANK_CYCLES=1, BLINK_HALF=32, BEEP_ON=3, BEEP_OFF=2, BEEP_COUNT=3.
- Scan: load 1,2,3,4,5,6 (hex0..hex5) with ld pulse -> dig_sel steps 3E,3D,3B,37,2F,1F, each low for 3 of 4 cycles with 1 blank cycle between. seg=F9,A4,30,99,12,82 (dp on digits 2 and 4).
- Shadow hold: change hex inputs to 9 with ld=0 -> display unchanged. Pulse ld -> next dwell of each digit shows 9 (seg=90).
- Invalid code: hex3=4'hC loaded -> digit 3 seg=BF. blink_mask=3'b010 -> digits 2,3 seg=FF for 32 cycles, shown for 32, repeating.
- Chime: chime_req 0->1 held 20 cycles -> buzzer pattern on 3 / off 2 / on 3 / off 2 / on 3, then 0. busy high for 13 cycles. Second edge mid-sequence -> no extra beep.
- Reset: assert key0 during second beep -> buzzer=0, seg=FF, dig_sel=3F immediately. Release with chime_req=1 -> no beep.
- Optional feature: hex5=0 -> digit 5 seg=FF with LEADING_ZERO_BLANK_EN, seg=C0 without.
